// File: rtl/bip_debug_pkg.sv
// bip_debug_pkg: shared states, host command bytes and report constants for the BIP debug unit
package bip_debug_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, WRITE, RUN, SEND, WAIT_TX} state_t;
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam int HALT_OPCODE = 0;
  localparam int REPORT_BYTES = 6;
endpackage

// File: rtl/bip_debug_if.sv
// bip_debug_if: UART, program-memory and CPU-control signals around the BIP debug unit
interface bip_debug_if #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16
);
  logic [7:0] rx_data, tx_data;
  logic rx_done, tx_start, tx_done, pm_we, cpu_enable, cpu_halt;
  logic [NBITS_O-1:0] pm_addr, cpu_pc;
  logic [NBITS_D-1:0] pm_data, cpu_acc;
  modport master (
    input rx_data, rx_done, tx_done, cpu_halt, cpu_pc, cpu_acc,
    output tx_data, tx_start, pm_we, pm_addr, pm_data, cpu_enable
  );
  modport slave (
    output rx_data, rx_done, tx_done, cpu_halt, cpu_pc, cpu_acc,
    input tx_data, tx_start, pm_we, pm_addr, pm_data, cpu_enable
  );
endinterface

// File: rtl/bip_debug_tx_seq.sv
// bip_debug_tx_seq: latches a six-byte PC/ACC/cycle report on i_start and pushes it out
// one byte per transmitter handshake, pulsing o_done after the last byte completes.
module bip_debug_tx_seq
  import bip_debug_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_pc,
  input  logic [15:0] i_acc,
  input  logic [15:0] i_cyc,
  input  logic        i_tx_done,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_done
);
  state_t st_q, st_d;
  logic [2:0] idx_q, idx_d;
  logic [8*REPORT_BYTES-1:0] rpt_q, rpt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_start_q, tx_start_d, done_q, done_d, last;
  always_comb begin
    last = idx_q == 3'(REPORT_BYTES - 1);
    st_d = st_q;
    idx_d = idx_q;
    rpt_d = rpt_q;
    tx_data_d = tx_data_q;
    tx_start_d = 1'b0;
    done_d = 1'b0;
    case (st_q)
      IDLE: if (i_start) begin
        rpt_d = {i_cyc, i_acc, i_pc};
        idx_d = '0;
        st_d = SEND;
      end
      SEND: begin
        tx_start_d = 1'b1;
        tx_data_d = rpt_q[{idx_q, 3'b000} +: 8];
        st_d = WAIT_TX;
      end
      WAIT_TX: if (i_tx_done) begin
        idx_d = idx_q + 3'd1;
        done_d = last;
        st_d = last ? IDLE : SEND;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      st_q <= IDLE;
      idx_q <= '0;
      rpt_q <= '0;
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      rpt_q <= rpt_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q <= done_d;
    end
  assign o_tx_data = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_done = done_q;
endmodule

// File: rtl/bip_debug_unit.sv
// bip_debug_unit: host-side loader/runner for the BIP CPU; builds program words from UART bytes,
// runs the CPU until HALT or counter saturation, then reports PC/ACC/cycles. BIP_DEBUG_STEP_EN adds 'S'.
module bip_debug_unit
  import bip_debug_pkg::*;
#(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE = 5,
  parameter int CELDAS = 10,
  parameter int NBITS_C = 16
) (
  input logic i_clock,
  input logic i_reset,
  bip_debug_if.master bus
);
  state_t state_q, state_d;
  logic [NBITS_O-1:0] ptr_q, ptr_d, ptr_inc, pm_addr_q, pm_addr_d;
  logic [NBITS_D-1:0] pm_data_q, pm_data_d;
  logic [NBITS_C-1:0] cyc_q, cyc_d;
  logic [7:0] lo_q, lo_d;
  logic pm_we_q, pm_we_d, cpu_en_q, cpu_en_d, start, sat, stop, run_exit, tx_fin;
`ifdef BIP_DEBUG_STEP_EN
  logic step_q, step_d;
`else
  logic step_q;
  assign step_q = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    lo_d = lo_q;
    cyc_d = cyc_q;
    pm_we_d = 1'b0;
    pm_addr_d = pm_addr_q;
    pm_data_d = pm_data_q;
    start = 1'b0;
`ifdef BIP_DEBUG_STEP_EN
    step_d = step_q;
`endif
    ptr_inc = ptr_q + NBITS_O'(1);
    sat = &cyc_q;
    stop = pm_data_q[NBITS_D-1 -: OPCODE] == OPCODE'(HALT_OPCODE) || ptr_inc == NBITS_O'(CELDAS);
    run_exit = step_q || bus.cpu_halt || sat;
    case (state_q)
      IDLE: if (bus.rx_done) begin
        state_d = bus.rx_data == CMD_LOAD ? LOAD_LO : bus.rx_data == CMD_RUN ? RUN : IDLE;
`ifdef BIP_DEBUG_STEP_EN
        step_d = bus.rx_data == CMD_STEP;
        if (bus.rx_data == CMD_STEP) state_d = RUN;
`endif
      end
      LOAD_LO: if (bus.rx_done) begin
        lo_d = bus.rx_data;
        state_d = LOAD_HI;
      end
      LOAD_HI: if (bus.rx_done) begin
        pm_we_d = 1'b1;
        pm_addr_d = ptr_q;
        pm_data_d = {bus.rx_data, lo_q};
        state_d = WRITE;
      end
      WRITE: begin
        ptr_d = stop ? '0 : ptr_inc;
        state_d = stop ? IDLE : LOAD_LO;
      end
      RUN: begin
        // a halted run reports the cycles already counted; a step always counts its one cycle
        cyc_d = sat || (!step_q && bus.cpu_halt) ? cyc_q : cyc_q + NBITS_C'(1);
        start = run_exit;
        state_d = run_exit ? SEND : RUN;
      end
      SEND: if (tx_fin) begin
        cyc_d = step_q ? cyc_q : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cpu_en_d = state_d == RUN;
  end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      lo_q <= '0;
      cyc_q <= '0;
      pm_we_q <= 1'b0;
      pm_addr_q <= '0;
      pm_data_q <= '0;
      cpu_en_q <= 1'b0;
`ifdef BIP_DEBUG_STEP_EN
      step_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      lo_q <= lo_d;
      cyc_q <= cyc_d;
      pm_we_q <= pm_we_d;
      pm_addr_q <= pm_addr_d;
      pm_data_q <= pm_data_d;
      cpu_en_q <= cpu_en_d;
`ifdef BIP_DEBUG_STEP_EN
      step_q <= step_d;
`endif
    end
  bip_debug_tx_seq u_tx_seq (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_start(start),
    .i_pc(16'(bus.cpu_pc)),
    .i_acc(16'(bus.cpu_acc)),
    .i_cyc(16'(cyc_d)),
    .i_tx_done(bus.tx_done),
    .o_tx_data(bus.tx_data),
    .o_tx_start(bus.tx_start),
    .o_done(tx_fin)
  );
  assign bus.pm_we = pm_we_q;
  assign bus.pm_addr = pm_addr_q;
  assign bus.pm_data = pm_data_q;
  assign bus.cpu_enable = cpu_en_q;
endmodule

// File: tb/tb_bip_debug_unit.sv
// tb_bip_debug_unit: scoreboard bench for bip_debug_unit (NBITS_C=4 so the timeout is reachable);
// honours BIP_DEBUG_STEP_EN to check either the step command or its absence.
module tb_bip_debug_unit;
  typedef struct {
    logic [7:0]  rx;
    logic        we;
    logic [10:0] addr;
    logic [15:0] data;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, halt_arm = 1'b0, tx_done_r = 1'b0, busy = 1'b0;
  int n_vec = 0, n_bad = 0, en_cnt = 0, en_base = 0, tx_cnt = 0;
  logic [26:0] pmq[$];
  logic [7:0] txq[$];
  vec_t vecs[5];
  always #5 clk = ~clk;
  bip_debug_if bus ();
  bip_debug_unit #(.NBITS_C(4)) dut (.i_clock(clk), .i_reset(rst_n), .bus(bus));
  assign bus.cpu_halt = halt_arm && (en_cnt - en_base >= 7);
  assign bus.tx_done = tx_done_r;
  always @(posedge clk) if (bus.cpu_enable) en_cnt <= en_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.pm_we) begin
      if (pmq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_pm_write: got addr %0h data %0h, required no write", bus.pm_addr, bus.pm_data);
      end else chk("pm_write", {bus.pm_addr, bus.pm_data}, 32'(pmq.pop_front()));
    end
  end

  always @(negedge clk) begin
    tx_done_r = 1'b0;
    if (bus.tx_start) begin
      chk("tx_start_while_busy", 32'(busy), 0);
      busy = 1'b1;
      tx_cnt = 4;
      if (txq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_tx: got byte %0h, required no transmission", bus.tx_data);
      end else chk("tx_byte", 32'(bus.tx_data), 32'(txq.pop_front()));
    end else if (busy) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done_r = 1'b1;
        busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((txq.size() != 0 || pmq.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (12) @(negedge clk);
    chk({nm, "_drained"}, 32'(txq.size() + pmq.size()), 0);
    chk({nm, "_cpu_idle"}, 32'(bus.cpu_enable), 0);
  endtask

  task automatic run_report(input string nm, input logic [7:0] cmd, input logic arm,
                            input logic [10:0] pc, input logic [15:0] acc, input logic [15:0] cyc);
    halt_arm = arm;
    bus.cpu_pc = pc;
    bus.cpu_acc = acc;
    en_base = en_cnt;
    txq.push_back(pc[7:0]);
    txq.push_back({5'b0, pc[10:8]});
    txq.push_back(acc[7:0]);
    txq.push_back(acc[15:8]);
    txq.push_back(cyc[7:0]);
    txq.push_back(cyc[15:8]);
    send_byte(cmd);
    drain(nm);
    halt_arm = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    bus.cpu_pc = '0;
    bus.cpu_acc = '0;
    vecs[0] = '{8'h4C, 1'b0, 11'h0, 16'h0};
    vecs[1] = '{8'h01, 1'b0, 11'h0, 16'h0};
    vecs[2] = '{8'h08, 1'b1, 11'h0, 16'h0801};
    vecs[3] = '{8'h00, 1'b0, 11'h0, 16'h0};
    vecs[4] = '{8'h00, 1'b1, 11'h1, 16'h0000};
    #12;
    chk("reset_pm_we", 32'(bus.pm_we), 0);
    chk("reset_tx_start", 32'(bus.tx_start), 0);
    chk("reset_cpu_enable", 32'(bus.cpu_enable), 0);
    chk("reset_pm_bus", {bus.pm_addr, bus.pm_data}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].we) pmq.push_back({vecs[i].addr, vecs[i].data});
      send_byte(vecs[i].rx);
    end
    drain("load_halt");
    en_base = en_cnt;
    send_byte(8'h01);
    repeat (10) @(negedge clk);
    chk("ignored_byte_enable", 32'(en_cnt - en_base), 0);

    send_byte(8'h4C);
    for (int i = 0; i < 11; i++) begin
      if (i < 10) pmq.push_back({11'(i), 16'h0800 + 16'(i)});
      send_byte(i < 10 ? 8'(i) : 8'h34);
      send_byte(i < 10 ? 8'h08 : 8'h12);
    end
    drain("load_full");

    run_report("run_halt", 8'h52, 1'b1, 11'h007, 16'hBEEF, 16'h0007);
    run_report("run_timeout", 8'h52, 1'b0, 11'h123, 16'h5A5A, 16'h000F);

`ifdef BIP_DEBUG_STEP_EN
    for (int k = 1; k <= 2; k++) begin
      run_report("step", 8'h53, 1'b0, 11'h042, 16'h1234, 16'(k));
      chk("step_enable_cycles", 32'(en_cnt - en_base), 1);
    end
`else
    en_base = en_cnt;
    send_byte(8'h53);
    repeat (20) @(negedge clk);
    chk("step_ignored_enable", 32'(en_cnt - en_base), 0);
`endif

    halt_arm = 1'b0;
    send_byte(8'h52);
    chk("run_enable_on", 32'(bus.cpu_enable), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_enable", 32'(bus.cpu_enable), 0);
    chk("async_reset_tx_start", 32'(bus.tx_start), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_enable", 32'(bus.cpu_enable), 0);
    pmq.push_back({11'h0, 16'hABCD});
    pmq.push_back({11'h1, 16'h0000});
    send_byte(8'h4C);
    send_byte(8'hCD);
    send_byte(8'hAB);
    send_byte(8'h00);
    send_byte(8'h00);
    drain("load_after_reset");
    run_report("run_after_reset", 8'h52, 1'b1, 11'h007, 16'hBEEF, 16'h0007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
